// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider : iterative restoring divider, one quotient bit per clock.
//
// Each iteration shifts the next dividend bit into the partial remainder R and
// trial-subtracts the divisor. The subtraction uses the add/sub datapath form:
// add ~B with carry-in 1. Carry-out 1 means no borrow, so the difference is kept
// and a 1 is shifted into Q. Carry-out 0 means R is restored and a 0 is
// shifted into Q.
//
// Handshake:
//   * start is accepted in IDLE only.
//   * busy is high from the cycle after acceptance until results are presented.
//   * done pulses for one cycle when quotient, remainder and div_by_zero update.
//
// Optional build macro: SEQ_DIVIDER_SIGNED_EN
//   When this macro is defined, the operands are two's complement. A PRE cycle
//   turns both operands into magnitudes. The unsigned core then runs. A POST
//   cycle applies the result signs: the quotient truncates toward zero and the
//   remainder takes the sign of the dividend.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIN
`ifdef SEQ_DIVIDER_SIGNED_EN
    ,
    S_PRE,
    S_POST
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_q;        // dividend in, quotient out (shift register)
  logic [WIDTH-1:0] r_d;        // captured divisor
  logic [WIDTH:0]   r_r;        // partial remainder
  logic [CW-1:0]    r_cnt;      // iterations still to run
  logic             r_dz;       // captured divisor was zero

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             r_sgn_n;    // dividend was negative
  logic             r_sgn_d;    // divisor was negative
`endif

  // Trial subtraction datapath. It is WIDTH+1 bits wide, so the shifted
  // remainder can never overflow.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_carry;
  logic             w_start_ok;
  logic             w_unused;

  // Shift the next dividend bit into the partial remainder.
  assign w_shift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

  // Add the inverted, zero-extended divisor with carry-in 1. Carry-out 1 means
  // there was no borrow.
  assign w_trial = {1'b0, w_shift}
                 + {1'b0, ~{1'b0, r_d}}
                 + {{(WIDTH + 1){1'b0}}, 1'b1};
  assign w_diff  = w_trial[WIDTH:0];
  assign w_carry = w_trial[WIDTH+1];

  // After any restore or subtract, the kept remainder is below the divisor.
  // Its top bit is therefore always zero and is never read back.
  assign w_unused = r_r[WIDTH];

  assign w_start_ok = (r_state == S_IDLE) && start;

`ifdef SEQ_DIVIDER_SIGNED_EN
  // Two's-complement negate in add/sub form: invert, then add one.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] a);
    return (~a) + {{(WIDTH - 1){1'b0}}, 1'b1};
  endfunction
`endif

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments. All
  //       registers then update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  // NOTE: the next-state signal gets a default before the case statement.
  //       Every path therefore assigns it, and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            w_state_next = S_FIN;
          end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            w_state_next = S_PRE;
`else
            w_state_next = S_CALC;
`endif
          end
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      S_PRE:  w_state_next = S_CALC;
      S_POST: w_state_next = S_FIN;
`endif
      S_CALC: begin
        if (r_cnt == CW'(1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          w_state_next = S_POST;
`else
          w_state_next = S_FIN;
`endif
        end
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, per-iteration shift/subtract, and sign fix-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_sgn_n <= 1'b0;
      r_sgn_d <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_d   <= divisor;
            r_cnt <= CW'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_sgn_n <= dividend[WIDTH-1];
            r_sgn_d <= divisor[WIDTH-1];
`endif
            if (divisor == '0) begin
              // Preload the divide-by-zero results; FIN only copies them out.
              r_q  <= '1;
              r_r  <= {1'b0, dividend};
              r_dz <= 1'b1;
            end else begin
              r_q  <= dividend;
              r_r  <= '0;
              r_dz <= 1'b0;
            end
          end
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        S_PRE: begin
          // Turn both operands into magnitudes. The most-negative value maps
          // onto itself, which is its correct unsigned magnitude.
          if (r_sgn_n) r_q <= negate(r_q);
          if (r_sgn_d) r_d <= negate(r_d);
        end
        S_POST: begin
          if (r_sgn_n ^ r_sgn_d) r_q <= negate(r_q);
          if (r_sgn_n) r_r <= {1'b0, negate(r_r[WIDTH-1:0])};
        end
`endif
        S_CALC: begin
          r_r   <= w_carry ? w_diff : w_shift;
          r_q   <= {r_q[WIDTH-2:0], w_carry};
          r_cnt <= r_cnt - CW'(1);
        end
        default: begin
          // FIN: the working registers hold their values.
        end
      endcase
    end
  end

  // Registered outputs. Results change only when leaving FIN and are held
  // until the next FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= (r_state == S_FIN);
      if (r_state == S_FIN) begin
        r_quotient    <= r_q;
        r_remainder   <= r_r[WIDTH-1:0];
        r_div_by_zero <= r_dz;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider : scoreboard bench for seq_divider (WIDTH = 4).
//
// The stimulus pushes the expected result for each accepted start, computed
// with plain integer division. A separate monitor pops one expectation per
// done pulse and compares it with the DUT outputs. Between results, the
// monitor also checks that the held outputs stay at the last result.
// Defining SEQ_DIVIDER_SIGNED_EN switches the model to signed arithmetic.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 4;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int BUSY_LEN = W + 3;
`else
  localparam int BUSY_LEN = W + 1;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           len;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t         scb[$];
  int           n_cmp;
  int           n_fail;
  int           busy_cnt;
  logic [2*W:0] hold;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, computed directly from integer division rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.len = 1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sa = int'($signed(a));
      int sb = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
`else
      int ua = int'(a);
      int ub = int'(b);
      e.q = W'(ua / ub);
      e.r = W'(ua % ub);
`endif
      e.dz  = 1'b0;
      e.len = BUSY_LEN;
    end
    return e;
  endfunction

  // Monitor: compares each done pulse against the scoreboard.
  initial begin
    busy_cnt = 0;
    hold     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        scb.delete();
        busy_cnt = 0;
        hold     = '0;
      end else begin
        if (busy) begin
          busy_cnt++;
          check("held_outputs", {quotient, remainder, div_by_zero}, hold);
        end
        if (done) begin
          check("done_expected", int'(scb.size() > 0), 1);
          if (scb.size() > 0) begin
            exp_t e;
            e = scb.pop_front();
            check("quotient",    quotient,    e.q);
            check("remainder",   remainder,   e.r);
            check("div_by_zero", div_by_zero, e.dz);
            check("busy_len",    busy_cnt,    e.len);
            check("busy_low_at_done", busy, 0);
            hold = {e.q, e.r, e.dz};
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Wait, within a bound, for a done pulse seen on a falling edge.
  task automatic wait_done();
    int got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("done_timeout", got, 1);
  endtask

  // Issue a start on the current falling edge, then return at the done cycle.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    scb.push_back(model(a, b));
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    wait_done();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    n_cmp    = 0;
    n_fail   = 0;
    gap(2);
    check("reset_state", {busy, done, quotient, remainder, div_by_zero}, '0);
    rst_n = 1'b1;
    gap(1);

    // Basic division.
    run(4'd13, 4'd3);
    gap(1);

    // Back-to-back: the second start is issued in the done cycle.
    run(4'd15, 4'd1);
    run(4'd3, 4'd7);
    gap(2);

    // Divide by zero, then a normal division that clears the flag.
    run(4'd5, 4'd0);
    gap(1);
    run(4'd13, 4'd3);
    gap(1);

    // A second start sampled at E2 must be ignored.
    scb.push_back(model(4'd9, 4'd2));
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd15; divisor = 4'd15;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    gap(3);
    check("no_extra_done", {busy, done}, '0);

    // Reset in the middle of a division aborts it with no done.
    start = 1'b1; dividend = 4'd11; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    gap(2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {busy, done, quotient, remainder, div_by_zero}, '0);
    gap(2);
    rst_n = 1'b1;
    gap(1);
    run(4'd14, 4'd4);
    gap(1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run(4'b1001, 4'b0010);
    gap(1);
    run(4'b0111, 4'b1110);
    gap(1);
    run(4'b1000, 4'b1111);
    gap(1);
`endif

    // Randomized operands, spacing and back-to-back issue.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
      run(a, b);
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end

    gap(3);
    check("scoreboard_drained", scb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
